// File: rtl/fixed_point_pkg.sv
// Shared types and width helpers for the fixed-point moving-average block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fixed_point_pkg;

  // Window fill phase: FILL until N samples seen, then RUN until flushed.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Running-sum width: N = 2^log2n samples of width bits cannot exceed this.
  function automatic int sum_width(input int width, input int log2n);
    return width + log2n;
  endfunction

  // Half of the divisor, added before the shift for round-half-up.
  function automatic int round_const(input int log2n);
    return 1 << (log2n - 1);
  endfunction

endpackage

// File: rtl/fixed_point_delay_line.sv
// N-entry sample buffer; one shared read/write address, read-before-write.
// Latency: read is combinational from the current address; write lands on the edge.
// Backpressure: none; a write is accepted every cycle i_we is high.
module fixed_point_delay_line #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [LOG2N-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int N = 1 << LOG2N;

  // Storage is deliberately left unreset; the owner masks stale entries.
  logic [WIDTH-1:0] mem [0:N-1];

  // The oldest sample is read out before being overwritten by the newest.
  assign o_rdata = mem[i_addr];

  // Write the accepted sample into the slot that just aged out.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/fixed_point_moving_avg.sv
// Moving average over the last N = 2^LOG2N signed fixed-point samples.
// Latency: outputs update on the accepting edge, valid the following cycle.
// Backpressure: none; sustains one sample per cycle, i_clear drops a coincident sample.
module fixed_point_moving_avg #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4,
  parameter int LOG2N = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic signed [WIDTH-1:0]        i_sample,
  input  logic                           i_overflow,
  input  logic                           i_clear,
  output logic                           o_valid,
  output logic signed [WIDTH-1:0]        o_avg,
  output logic signed [WIDTH+LOG2N-1:0]  o_sum,
  output logic                           o_primed,
  output logic                           o_ovf_sticky
);

  import fixed_point_pkg::*;

  localparam int N  = 1 << LOG2N;
  localparam int SW = sum_width(WIDTH, LOG2N);
  localparam logic signed [SW-1:0] RND  = SW'(round_const(LOG2N));
  localparam logic [LOG2N:0]       LAST = (LOG2N + 1)'(N - 1);

  state_t                  state;
  logic [LOG2N-1:0]        wr_ptr;
  logic [LOG2N:0]          count;
  logic                    accept;
  logic                    buf_we;
  logic [WIDTH-1:0]        leave_dat;
  logic signed [SW-1:0]    samp_ext;
  logic signed [SW-1:0]    leave_ext;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW-1:0]    rounded;
  logic signed [WIDTH-1:0] avg_next;

  // A clear in the same cycle as a sample wins and the sample is dropped.
  assign accept = i_valid & ~i_clear;
  assign buf_we = accept & ~i_rst;

  fixed_point_delay_line #(
    .WIDTH (WIDTH),
    .LOG2N (LOG2N)
  ) u_delay_line (
    .i_clk   (i_clk),
    .i_we    (buf_we),
    .i_addr  (wr_ptr),
    .i_wdata (i_sample),
    .o_rdata (leave_dat)
  );

  // Next window sum and its rounded mean; the leaving term is zero while filling
  // so unreset buffer contents never leak in.
  always_comb begin
    samp_ext  = {{LOG2N{i_sample[WIDTH-1]}}, i_sample};
    leave_ext = '0;
    if (state == RUN) begin
      leave_ext = {{LOG2N{leave_dat[WIDTH-1]}}, leave_dat};
    end
    sum_next = o_sum + samp_ext - leave_ext;
    // The sum is at most N*(2^(WIDTH-1)-1), so adding N/2 cannot wrap.
    rounded  = sum_next + RND;
    avg_next = WIDTH'(rounded >>> LOG2N);
  end

  // Fill/run control, window bookkeeping and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state        <= FILL;
      wr_ptr       <= '0;
      count        <= '0;
      o_valid      <= 1'b0;
      o_avg        <= '0;
      o_sum        <= '0;
      o_primed     <= 1'b0;
      o_ovf_sticky <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_sum  <= sum_next;
        o_avg  <= avg_next;
        wr_ptr <= wr_ptr + 1'b1;
        if (i_overflow) begin
          o_ovf_sticky <= 1'b1;
        end
        if (state == FILL) begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state    <= RUN;
            o_primed <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_moving_avg.sv
// Self-checking bench for fixed_point_moving_avg at WIDTH=8, LOG2N=2.
// Latency: each step drives inputs, waits one edge, then compares outputs.
// Backpressure: n/a; the design never stalls.
module tb_fixed_point_moving_avg;

  localparam int WIDTH = 8;
  localparam int FBITS = 4;
  localparam int LOG2N = 2;
  localparam int N     = 1 << LOG2N;

  logic                           i_clk;
  logic                           i_rst;
  logic                           i_valid;
  logic signed [WIDTH-1:0]        i_sample;
  logic                           i_overflow;
  logic                           i_clear;
  logic                           o_valid;
  logic signed [WIDTH-1:0]        o_avg;
  logic signed [WIDTH+LOG2N-1:0]  o_sum;
  logic                           o_primed;
  logic                           o_ovf_sticky;

  int checks;
  int failures;

  // Reference model: the window as a queue of the last N accepted samples.
  int win[$];
  int m_sum;
  int m_avg;
  int m_accepted;
  bit m_valid;
  bit m_primed;
  bit m_sticky;
  bit avg_known;

  fixed_point_moving_avg #(
    .WIDTH (WIDTH),
    .FBITS (FBITS),
    .LOG2N (LOG2N)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_sample     (i_sample),
    .i_overflow   (i_overflow),
    .i_clear      (i_clear),
    .o_valid      (o_valid),
    .o_avg        (o_avg),
    .o_sum        (o_sum),
    .o_primed     (o_primed),
    .o_ovf_sticky (o_ovf_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mean of the zero-padded window, rounding halves toward +infinity.
  function automatic int round_mean(input int s);
    int t;
    t = s + N / 2;
    if (t >= 0) return t / N;
    return -((-t + N - 1) / N);
  endfunction

  task automatic model_flush(input bit is_rst);
    win.delete();
    m_sum      = 0;
    m_accepted = 0;
    m_valid    = 1'b0;
    m_primed   = 1'b0;
    m_sticky   = 1'b0;
    if (is_rst) begin
      m_avg     = 0;
      avg_known = 1'b1;
    end else begin
      avg_known = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("sum", o_sum, 32'(10'(m_sum)));
    if (avg_known) chk("avg", o_avg, 32'(8'(m_avg)));
    chk("primed", 32'(o_primed), 32'(m_primed));
    chk("sticky", 32'(o_ovf_sticky), 32'(m_sticky));
  endtask

  // One clock: drive, clock, update the model, compare away from the edge.
  task automatic cyc(input bit v, input logic [7:0] s, input bit ovf,
                     input bit clr, input bit rst);
    i_valid    = v;
    i_sample   = s;
    i_overflow = ovf;
    i_clear    = clr;
    i_rst      = rst;
    @(posedge i_clk);
    #1;
    if (rst || clr) begin
      model_flush(rst);
    end else if (v) begin
      win.push_back(int'($signed(s)));
      if (win.size() > N) void'(win.pop_front());
      m_accepted++;
      m_sum = 0;
      foreach (win[k]) m_sum += win[k];
      m_avg     = round_mean(m_sum);
      m_primed  = (m_accepted >= N);
      m_sticky  = m_sticky | ovf;
      m_valid   = 1'b1;
      avg_known = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    i_valid    = 1'b0;
    i_overflow = 1'b0;
    i_clear    = 1'b0;
    i_rst      = 1'b0;
    compare_all();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_sample   = '0;
    i_overflow = 1'b0;
    i_clear    = 1'b0;
    model_flush(1'b1);

    // Reset state.
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("rst_sum", o_sum, 0);
    chk("rst_avg", o_avg, 0);
    chk("rst_valid", 32'(o_valid), 0);

    // Fill with four 0x10.
    cyc(1, 8'h10, 0, 0, 0);
    chk("fill1_sum", o_sum, 32'h10);
    chk("fill1_avg", o_avg, 32'h04);
    chk("fill1_primed", 32'(o_primed), 0);
    cyc(1, 8'h10, 0, 0, 0);
    chk("fill2_avg", o_avg, 32'h08);
    cyc(1, 8'h10, 0, 0, 0);
    chk("fill3_sum", o_sum, 32'h30);
    chk("fill3_primed", 32'(o_primed), 0);
    cyc(1, 8'h10, 0, 0, 0);
    chk("fill4_sum", o_sum, 32'h40);
    chk("fill4_avg", o_avg, 32'h10);
    chk("fill4_primed", 32'(o_primed), 1);

    // Run phase with pointer wrap.
    cyc(1, 8'h20, 0, 0, 0);
    chk("run1_sum", o_sum, 32'h50);
    chk("run1_avg", o_avg, 32'h14);
    cyc(1, 8'h20, 0, 0, 0);
    chk("run2_sum", o_sum, 32'h60);
    chk("run2_avg", o_avg, 32'h18);

    // Idle cycles hold outputs.
    cyc(0, 8'h55, 0, 0, 0);
    chk("idle_sum", o_sum, 32'h60);
    chk("idle_valid", 32'(o_valid), 0);

    // Extremes: full positive window, then full negative window.
    cyc(0, 8'h00, 0, 1, 0);
    repeat (N) cyc(1, 8'h7F, 0, 0, 0);
    chk("max_sum", o_sum, 32'h1FC);
    chk("max_avg", o_avg, 127);
    repeat (N) cyc(1, 8'h80, 0, 0, 0);
    chk("min_sum", o_sum, -512);
    chk("min_avg", o_avg, -128);

    // Rounding boundary.
    cyc(0, 8'h00, 0, 1, 0);
    cyc(1, 8'h01, 0, 0, 0);
    repeat (3) cyc(1, 8'h00, 0, 0, 0);
    chk("round_1", o_avg, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(1, 8'h02, 0, 0, 0);
    repeat (3) cyc(1, 8'h00, 0, 0, 0);
    chk("round_2", o_avg, 1);

    // Sticky overflow and clear-beats-valid.
    cyc(1, 8'h08, 1, 0, 0);
    chk("sticky_set", 32'(o_ovf_sticky), 1);
    cyc(1, 8'h08, 0, 0, 0);
    chk("sticky_hold", 32'(o_ovf_sticky), 1);
    cyc(1, 8'h33, 1, 1, 0);
    chk("clr_valid", 32'(o_valid), 0);
    chk("clr_sum", o_sum, 0);
    chk("clr_sticky", 32'(o_ovf_sticky), 0);
    chk("clr_primed", 32'(o_primed), 0);

    // Reset mid-window, then the fill sequence must repeat exactly.
    cyc(1, 8'h40, 0, 0, 0);
    cyc(1, 8'h40, 0, 0, 0);
    cyc(1, 8'h40, 0, 0, 1);
    chk("rst2_sum", o_sum, 0);
    chk("rst2_avg", o_avg, 0);
    chk("rst2_primed", 32'(o_primed), 0);
    cyc(1, 8'h10, 0, 0, 0);
    chk("refill1_sum", o_sum, 32'h10);
    repeat (2) cyc(1, 8'h10, 0, 0, 0);
    chk("refill3_primed", 32'(o_primed), 0);
    cyc(1, 8'h10, 0, 0, 0);
    chk("refill4_sum", o_sum, 32'h40);
    chk("refill4_avg", o_avg, 32'h10);
    chk("refill4_primed", 32'(o_primed), 1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), 8'($urandom),
          ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
